uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: the receive-side counterpart to `uart_tx`, using the same 8N1 framing and the same 2604-clock bit period (19200 baud at 50 MHz). It synchronizes the asynchronous `rx` line and detects the start bit. Each bit is sampled at mid-bit, and the assembled byte is presented with a ready flag. It sits between the external serial pin and the command/packet logic, and is looped back against `uart_tx` for system test.

## Interface
- `BAUD_CYCLES`, default 2604: clocks per bit. Must be even and ≥ 8.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; one clock; asynchronous, active-low.
- `rx`  input  1  serial line, idle high; asynchronous to `clk`.
- `clr_rdy`  input  1  consumer acknowledge; clears `rx_rdy`.
- `rx_data`  output  8  last correctly framed byte.
- `rx_rdy`  output  1  new byte available; held until cleared.
- `frame_err`  output  1  last frame had stop bit = 0; held until the next frame completes.

## Operation
- Synchronizer:
  - Two flops plus one edge-history flop on `rx`, all reset to 1.
  - Falling edge = history 1 and synchronized 0.
- Baud counter:
  - Width is ceil(log2(BAUD_CYCLES)).
  - Decrements every clock outside IDLE.
  - "Tick" = counter == 0 in a non-IDLE state; the sample is taken that cycle.
- Bit counter: 4 bits, counts received data bits from 0 to 8.
- Shift register: 8 bits, right shift, and the sampled bit enters the MSB. The LSB arrives first, so after 8 shifts bit 0 sits in [0].
- State machine:
  - IDLE: on a falling edge, load counter with BAUD_CYCLES/2−1, clear `rx_rdy`, go to START.
  - START: on tick, if synchronized rx = 0, load counter with BAUD_CYCLES−1, clear bit count, go to DATA. If rx = 1 (glitch), go to IDLE with no output change except the `rx_rdy` clear already done.
  - DATA: on tick, shift in rx, increment bit count, reload BAUD_CYCLES−1. After the 8th shift, go to STOP.
  - STOP, tick with rx = 1: `rx_data` ← shift register, `rx_rdy` ← 1, `frame_err` ← 0.
  - STOP, tick with rx = 0: `frame_err` ← 1; `rx_data` and `rx_rdy` are unchanged.
  - STOP, either case: go to IDLE.
- After a framing error the line may still be low. IDLE accepts a start only on a true 1→0 edge, so a stuck-low line produces no further frames.
- `rx_rdy` priority: set in STOP > clear by `clr_rdy` > clear on start detect > hold. If `clr_rdy` lands in the same cycle as the STOP set, `rx_rdy` is 1.
- `rx_data` changes only on a good stop bit. It is stable for the whole period `rx_rdy` = 1 and after `rx_rdy` is cleared.
- No FIFO. An unacknowledged byte is overwritten by the next good frame; no overrun flag.

## Timing
- Reset values: state IDLE, counters 0, shift register 0x00, `rx_data` 0x00, `rx_rdy` 0, `frame_err` 0, sync flops 1.
- Reset asserted mid-frame aborts the frame immediately. Outputs return to reset values, and the partial byte is discarded.
- Edge detect occurs 3 clocks after `rx` first reads low at a rising edge (2 sync flops plus the history flop).
- Sample points, counted from the edge-detect cycle:
  - start bit at BAUD_CYCLES/2;
  - data bit k at BAUD_CYCLES/2 + (k+1)·BAUD_CYCLES;
  - stop bit at BAUD_CYCLES/2 + 9·BAUD_CYCLES.
- `rx_rdy` and `rx_data` update at the clock edge ending the stop-sample cycle. Total delay from the pin falling edge to `rx_rdy` high is 9.5·BAUD_CYCLES + 3 (24741 at default). Benches allow ±2.
- Back-to-back frames are supported: the FSM is in IDLE by mid-stop-bit, so a start edge at the end of the stop bit is caught.
- `clr_rdy` takes effect next edge; a one-cycle pulse suffices.

## Test plan
- **Single frame:** send 0xE3 (start 0, bits LSB-first 1,1,0,0,0,1,1,1, stop 1) at 2604 clk/bit. Require:
  - `rx_rdy` rises at 24741±2 clocks after the start edge;
  - `rx_data` = 0xE3, `frame_err` = 0;
  - `rx_rdy` stays high until `clr_rdy` is pulsed, then 0 on the next cycle.
- **Back-to-back, no acknowledge:** send 0xA5 then 0x5A with no idle gap and no `clr_rdy`. Require `rx_rdy` = 1 with 0xA5, then falling at the second start edge, then 1 with 0x5A at the second stop sample.
- **Glitch rejection:** drive `rx` low for 100 clocks, then high. Require return to IDLE after the start tick, `rx_rdy` = 0, and `rx_data` unchanged.
- **Framing error:** send 0x3C with stop bit 0, holding the line low for 3 more bit times, then high. Require:
  - `frame_err` = 1, `rx_rdy` = 0, `rx_data` holds its prior value;
  - no spurious frame while the line is low;
  - a following good 0x81 gives `rx_data` = 0x81, `frame_err` = 0.
- **Reset mid-frame:** assert `rst_n` = 0 during data bit 4 of 0xFF. Require all outputs at reset values immediately. After release, a clean 0x42 is received correctly.
- **Loopback:** `uart_tx` → `uart_rx` for all 256 byte values with `clr_rdy` after each. Require every byte to match and `frame_err` never set.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, finds the start edge, samples mid-bit
// and presents each well-framed byte with a sticky ready flag.
module uart_rx #(
    parameter int BAUD_CYCLES = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frame_err
);

    localparam int W = $clog2(BAUD_CYCLES);

    localparam logic [W-1:0] HALF = W'(BAUD_CYCLES / 2 - 1);
    localparam logic [W-1:0] FULL = W'(BAUD_CYCLES - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]   state;
    logic [W-1:0] cnt;
    logic [3:0]   bit_cnt;
    logic [7:0]   shreg;
    logic         sync1;
    logic         sync2;
    logic         hist;
    logic         fall;
    logic         tick;
    logic         good_stop;

    assign fall      = hist & ~sync2;
    assign tick      = (state != IDLE) && (cnt == '0);
    assign good_stop = (state == STOP) && tick && sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            if (state != IDLE) begin
                cnt <= cnt - ONE;
            end
            case (state)
                IDLE: begin
                    if (fall) begin
                        cnt   <= HALF;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!sync2) begin
                            cnt     <= FULL;
                            bit_cnt <= 4'd0;
                            state   <= DATA;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= {sync2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        cnt     <= FULL;
                        if (bit_cnt == 4'd7) begin
                            state <= STOP;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (sync2) begin
                            rx_data   <= shreg;
                            frame_err <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // A completed frame wins over an acknowledge landing in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy <= 1'b0;
        end else if (good_stop) begin
            rx_rdy <= 1'b1;
        end else if (clr_rdy) begin
            rx_rdy <= 1'b0;
        end else if (state == IDLE && fall) begin
            rx_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: full-rate single frame on a 2604-clock instance,
// corner cases, vector table, random frames and 256-byte loopback at 8 clk/bit.
module tb_uart_rx;

    localparam int BB = 2604;
    localparam int SB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] b_data;
    logic       b_rdy;
    logic       b_ferr;
    logic [7:0] s_data;
    logic       s_rdy;
    logic       s_ferr;

    always #5 clk = ~clk;

    // Both instances share the line; only one is checked at a time
    uart_rx #(.BAUD_CYCLES(BB)) u_big (
        .clk(clk), .rst_n(rst_n), .rx(rx), .clr_rdy(clr_rdy),
        .rx_data(b_data), .rx_rdy(b_rdy), .frame_err(b_ferr)
    );

    uart_rx #(.BAUD_CYCLES(SB)) u_small (
        .clk(clk), .rst_n(rst_n), .rx(rx), .clr_rdy(clr_rdy),
        .rx_data(s_data), .rx_rdy(s_rdy), .frame_err(s_ferr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int b_rise = -1;
    logic b_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b_rdy && !b_prev && b_rise < 0) b_rise <= cyc;
        b_prev <= b_rdy;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       clr;
        logic [7:0] ed;
        logic       er;
        logic       ef;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        wait_clk(n);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int bp);
        drive(1'b0, bp);
        for (int i = 0; i < 8; i++) drive(d[i], bp);
        drive(stop, bp);
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        wait_clk(1);
        clr_rdy = 1'b0;
    endtask

    initial begin
        int t0;
        int lat;
        logic [7:0] m_data;
        logic m_rdy;
        logic m_ferr;
        logic [7:0] q[$];
        logic [7:0] exp_b;

        tbl[0] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h7E, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[4] = '{8'hAA, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0};
        tbl[5] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1};

        wait_clk(3);
        check("rst_b_data", b_data, 8'h00);
        check("rst_b_rdy", b_rdy, 1'b0);
        check("rst_b_ferr", b_ferr, 1'b0);
        check("rst_s_data", s_data, 8'h00);
        check("rst_s_rdy", s_rdy, 1'b0);
        check("rst_s_ferr", s_ferr, 1'b0);
        rst_n = 1'b1;
        wait_clk(3);

        // full-rate frame: latency from pin edge to rx_rdy
        t0 = cyc;
        send(8'hE3, 1'b1, BB);
        lat = b_rise - t0;
        checks++;
        if (b_rise < 0 || lat < 24739 || lat > 24743) begin
            errors++;
            $display("FAIL latency got %0d expected 24741+-2", lat);
        end
        check("single_data", b_data, 8'hE3);
        check("single_ferr", b_ferr, 1'b0);
        wait_clk(50);
        check("single_hold", b_rdy, 1'b1);
        pulse_clr();
        check("single_clr", b_rdy, 1'b0);

        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);

        // back-to-back without acknowledge
        send(8'hA5, 1'b1, SB);
        check("b2b_rdy1", s_rdy, 1'b1);
        check("b2b_data1", s_data, 8'hA5);
        drive(1'b0, 5);
        check("b2b_clear", s_rdy, 1'b0);
        drive(1'b0, SB - 5);
        for (int i = 0; i < 8; i++) drive(exp_b_bit(8'h5A, i), SB);
        drive(1'b1, SB);
        check("b2b_rdy2", s_rdy, 1'b1);
        check("b2b_data2", s_data, 8'h5A);
        check("b2b_ferr", s_ferr, 1'b0);

        // glitch shorter than half a bit
        drive(1'b0, 3);
        drive(1'b1, SB * 12);
        check("glitch_rdy", s_rdy, 1'b0);
        check("glitch_data", s_data, 8'h5A);
        check("glitch_ferr", s_ferr, 1'b0);
        send(8'hC3, 1'b1, SB);
        check("post_glitch_data", s_data, 8'hC3);
        check("post_glitch_rdy", s_rdy, 1'b1);

        // framing error, line stuck low afterwards
        send(8'h3C, 1'b0, SB);
        check("ferr_set", s_ferr, 1'b1);
        check("ferr_rdy", s_rdy, 1'b0);
        check("ferr_data", s_data, 8'hC3);
        drive(1'b0, 3 * SB);
        check("stuck_ferr", s_ferr, 1'b1);
        check("stuck_rdy", s_rdy, 1'b0);
        check("stuck_data", s_data, 8'hC3);
        drive(1'b1, 2 * SB);
        send(8'h81, 1'b1, SB);
        check("recover_data", s_data, 8'h81);
        check("recover_ferr", s_ferr, 1'b0);
        check("recover_rdy", s_rdy, 1'b1);

        // reset during data bit 4 of 0xFF
        drive(1'b0, SB);
        for (int i = 0; i < 4; i++) drive(1'b1, SB);
        drive(1'b1, SB / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_data", s_data, 8'h00);
        check("midrst_rdy", s_rdy, 1'b0);
        check("midrst_ferr", s_ferr, 1'b0);
        rx = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        send(8'h42, 1'b1, SB);
        check("after_rst_data", s_data, 8'h42);
        check("after_rst_rdy", s_rdy, 1'b1);
        check("after_rst_ferr", s_ferr, 1'b0);
        drive(1'b1, 2);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].clr) pulse_clr();
            send(tbl[i].d, tbl[i].stop, SB);
            check($sformatf("vec%0d_data", i), s_data, tbl[i].ed);
            check($sformatf("vec%0d_rdy", i), s_rdy, tbl[i].er);
            check($sformatf("vec%0d_ferr", i), s_ferr, tbl[i].ef);
            drive(1'b1, 2);
        end

        // random frames against a frame-level model
        m_data = tbl[6].ed;
        m_rdy = tbl[6].er;
        m_ferr = tbl[6].ef;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            logic st;
            d = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                m_rdy = 1'b0;
            end
            send(d, st, SB);
            m_rdy = 1'b0;
            if (st) begin
                m_data = d;
                m_rdy = 1'b1;
                m_ferr = 1'b0;
            end else begin
                m_ferr = 1'b1;
            end
            check($sformatf("rnd%0d_data", i), s_data, m_data);
            check($sformatf("rnd%0d_rdy", i), s_rdy, m_rdy);
            check($sformatf("rnd%0d_ferr", i), s_ferr, m_ferr);
            drive(1'b1, $urandom_range(2, 20));
        end

        // loopback of every byte value
        for (int v = 0; v < 256; v++) begin
            q.push_back(8'(v));
            send(8'(v), 1'b1, SB);
            exp_b = q.pop_front();
            check($sformatf("loop%0d_data", v), s_data, exp_b);
            check($sformatf("loop%0d_rdy", v), s_rdy, 1'b1);
            check($sformatf("loop%0d_ferr", v), s_ferr, 1'b0);
            pulse_clr();
            check($sformatf("loop%0d_clr", v), s_rdy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic exp_b_bit(input logic [7:0] d, input int i);
        return d[i];
    endfunction

endmodule
